// File: rtl/ysyx_23060184_ifu_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ysyx_23060184_ifu_pkg
// Brief    : Shared types and constants for the instruction fetch unit.
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_23060184_ifu_pkg;

    localparam int          INST_W           = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] EBREAK_INST      = 32'h0010_0073;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2,
        S_HALT = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ysyx_23060184_ifu_outreg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060184_ifu_outreg
// Brief    : Holding register for the instruction presented to decode.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060184_ifu_outreg
    import ysyx_23060184_ifu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [INST_W-1:0] load_inst,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic              load_err,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_err
);

    logic              r_valid;
    logic [INST_W-1:0] r_inst;
    logic [ADDR_W-1:0] r_pc;
    logic              r_err;

    // Payload only changes on load, so it holds for as long as decode stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_inst  <= '0;
            r_pc    <= '0;
            r_err   <= 1'b0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_inst  <= load_inst;
            r_pc    <= load_pc;
            r_err   <= load_err;
        end else if (clear) begin
            r_valid <= 1'b0;
        end
    end

    assign inst_valid = r_valid;
    assign inst       = r_inst;
    assign inst_pc    = r_pc;
    assign inst_err   = r_err;

endmodule
`default_nettype wire

// File: rtl/ysyx_23060184_ifu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060184_ifu
// Brief    : Instruction fetch unit: PC, one-outstanding imem port, decode port.
// Options  : YSYX_23060184_IFU_EBREAK_HALT_EN - stop fetching after ebreak.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060184_ifu
    import ysyx_23060184_ifu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    input  logic              imem_rsp_err,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_err,
    output logic              halted
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_drop;

    logic [ADDR_W-1:0] w_target;
    logic              w_rsp_take;
    logic              w_out_clear;
    logic              w_halt_go;

    assign w_target    = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign w_rsp_take  = (r_state == S_WAIT) && imem_rsp_valid && !r_drop && !redirect_valid;
    assign w_out_clear = (r_state == S_OUT) && (inst_ready || redirect_valid);

`ifdef YSYX_23060184_IFU_EBREAK_HALT_EN
    assign w_halt_go = (inst == EBREAK_INST) && !inst_err;
    assign halted    = (r_state == S_HALT);
`else
    assign w_halt_go = 1'b0;
    assign halted    = 1'b0;
`endif

    assign imem_req_valid = (r_state == S_REQ);
    assign imem_req_addr  = r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
            r_drop  <= 1'b0;
        end else begin
            case (r_state)
                S_REQ: begin
                    // A redirect racing the handshake leaves a stale request in flight.
                    if (imem_req_ready) begin
                        r_state <= S_WAIT;
                        r_drop  <= redirect_valid;
                    end
                    if (redirect_valid) begin
                        r_pc <= w_target;
                    end
                end
                S_WAIT: begin
                    if (redirect_valid) begin
                        r_pc <= w_target;
                    end
                    if (imem_rsp_valid) begin
                        r_drop  <= 1'b0;
                        r_state <= (r_drop || redirect_valid) ? S_REQ : S_OUT;
                    end else if (redirect_valid) begin
                        r_drop <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (redirect_valid) begin
                        r_pc    <= w_target;
                        r_state <= S_REQ;
                    end else if (inst_ready) begin
                        r_pc    <= r_pc + ADDR_W'(4);
                        r_state <= w_halt_go ? S_HALT : S_REQ;
                    end
                end
`ifdef YSYX_23060184_IFU_EBREAK_HALT_EN
                S_HALT: begin
                    if (redirect_valid) begin
                        r_pc    <= w_target;
                        r_state <= S_REQ;
                    end
                end
`endif
                default: begin
                    r_state <= S_REQ;
                end
            endcase
        end
    end

    ysyx_23060184_ifu_outreg #(
        .ADDR_W (ADDR_W)
    ) u_outreg (
        .clk        (clk),
        .rst        (rst),
        .load       (w_rsp_take),
        .clear      (w_out_clear),
        .load_inst  (imem_rsp_data),
        .load_pc    (r_pc),
        .load_err   (imem_rsp_err),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_err   (inst_err)
    );

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060184_ifu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_23060184_ifu
// Brief    : Self-checking bench with a memory responder and PC-stream model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060184_ifu;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_err;
    logic        halted;

    int checks = 0;
    int errors = 0;

    // memory responder state
    bit          pend;
    int          pend_cnt;
    logic [31:0] pend_addr;
    int          lat_cur;
    bit          overlap;
    bit          fixed_en;
    bit          err_pat;
    logic [31:0] ovr_addr, ovr_data, err_addr;

    // observed handshakes
    int          n_req, n_inst;
    logic [31:0] last_inst_pc;

    ysyx_23060184_ifu dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_err       (inst_err),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        logic [31:0] h;
        if (a == ovr_addr) return ovr_data;
        if (fixed_en) return 32'h0000_0013;
        h = (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
        if (h == 32'h0010_0073) h = h ^ 32'h1;
        return h;
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return (a == err_addr) || (err_pat && (a[5:2] == 4'hB));
    endfunction

    // One clock: log handshakes seen before the edge, then play the memory.
    task automatic tick();
        bit req_hs;
        req_hs = !rst && imem_req_valid && imem_req_ready;
        if (!rst && inst_valid && inst_ready) begin
            n_inst++;
            last_inst_pc = inst_pc;
        end
        if (req_hs) begin
            if (pend || imem_rsp_valid) overlap = 1'b1;
            n_req++;
        end
        if (req_hs) pend_addr = imem_req_addr;
        @(posedge clk);
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_err   = 1'b0;
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (req_hs) begin
                pend     = 1'b1;
                pend_cnt = lat_cur;
            end
            if (pend) begin
                if (pend_cnt <= 1) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_data(pend_addr);
                    imem_rsp_err   = mem_err(pend_addr);
                    pend           = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
        end
    endtask

    task automatic wait_inst(output bit ok);
        for (int i = 0; i < 40 && inst_valid !== 1'b1; i++) tick();
        ok = (inst_valid === 1'b1);
    endtask

    task automatic reset_dut();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        imem_req_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        checks++;
        if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0 ||
            inst_err !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b i=%h pc=%h e=%b h=%b want all zero",
                     inst_valid, inst, inst_pc, inst_err, halted);
        end
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin
            errors++;
            $display("FAIL reset_req got v=%b a=%h want v=1 a=80000000", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_zero_wait();
        fixed_en       = 1'b1;
        lat_cur        = 1;
        imem_req_ready = 1'b1;
        tick();
        checks++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL zw_cycle1 got req=%b iv=%b want 0 0", imem_req_valid, inst_valid);
        end
        tick();
        checks++;
        if (inst_valid !== 1'b1 || inst !== 32'h13 || inst_pc !== 32'h8000_0000 || inst_err !== 1'b0) begin
            errors++;
            $display("FAIL zw_inst got v=%b i=%h pc=%h e=%b want 1 00000013 80000000 0",
                     inst_valid, inst, inst_pc, inst_err);
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0004 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL zw_next_req got v=%b a=%h iv=%b want 1 80000004 0",
                     imem_req_valid, imem_req_addr, inst_valid);
        end
    endtask

    task automatic test_stall();
        bit ok;
        int r0;
        wait_inst(ok);
        checks++;
        if (!ok || inst_pc !== 32'h8000_0004) begin
            errors++;
            $display("FAIL stall_arrive got ok=%b pc=%h want 1 80000004", ok, inst_pc);
        end
        r0 = n_req;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (inst_valid !== 1'b1 || inst !== 32'h13 || inst_pc !== 32'h8000_0004 || imem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d] got v=%b i=%h pc=%h req=%b want 1 00000013 80000004 0",
                         i, inst_valid, inst, inst_pc, imem_req_valid);
            end
        end
        checks++;
        if (n_req !== r0) begin
            errors++;
            $display("FAIL stall_noreq got %0d want %0d", n_req, r0);
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
    endtask

    task automatic test_redirect_wait();
        bit ok, saw;
        int i0;
        lat_cur = 4;
        tick();
        lat_cur = 1;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL rw_in_wait got req=%b want 0", imem_req_valid);
        end
        i0             = n_inst;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        tick();
        redirect_valid = 1'b0;
        saw            = 1'b0;
        for (int i = 0; i < 20 && imem_req_valid !== 1'b1; i++) begin
            saw = saw | (inst_valid === 1'b1);
            tick();
        end
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100) begin
            errors++;
            $display("FAIL rw_next_req got v=%b a=%h want 1 80000100", imem_req_valid, imem_req_addr);
        end
        checks++;
        if (saw || n_inst !== i0 || overlap) begin
            errors++;
            $display("FAIL rw_stale got saw=%b n=%0d ovl=%b want 0 %0d 0", saw, n_inst, overlap, i0);
        end
        wait_inst(ok);
        checks++;
        if (!ok || inst_pc !== 32'h8000_0100) begin
            errors++;
            $display("FAIL rw_target got ok=%b pc=%h want 1 80000100", ok, inst_pc);
        end
    endtask

    task automatic test_redirect_handshake();
        bit ok;
        int i0;
        i0             = n_inst;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0010;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || n_inst !== i0 || imem_req_addr !== 32'h8000_0010) begin
            errors++;
            $display("FAIL rh_drop got iv=%b n=%0d a=%h want 0 %0d 80000010", inst_valid, n_inst, imem_req_addr, i0);
        end
        wait_inst(ok);
        checks++;
        if (!ok || inst_pc !== 32'h8000_0010) begin
            errors++;
            $display("FAIL rh_arrive got ok=%b pc=%h want 1 80000010", ok, inst_pc);
        end
        i0             = n_inst;
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        tick();
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        checks++;
        if (n_inst !== i0 + 1 || last_inst_pc !== 32'h8000_0010 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL rh_once got n=%0d pc=%h iv=%b want %0d 80000010 0", n_inst, last_inst_pc, inst_valid, i0 + 1);
        end
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0200) begin
            errors++;
            $display("FAIL rh_next_req got v=%b a=%h want 1 80000200", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_err();
        bit ok;
        err_addr       = 32'h8000_0008;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0008;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0008) begin
            errors++;
            $display("FAIL err_retarget got v=%b a=%h want 1 80000008", imem_req_valid, imem_req_addr);
        end
        imem_req_ready = 1'b1;
        wait_inst(ok);
        checks++;
        if (!ok || inst_pc !== 32'h8000_0008 || inst_err !== 1'b1 || inst !== 32'h13) begin
            errors++;
            $display("FAIL err_flag got ok=%b pc=%h e=%b i=%h want 1 80000008 1 00000013", ok, inst_pc, inst_err, inst);
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_000C) begin
            errors++;
            $display("FAIL err_continue got v=%b a=%h want 1 8000000c", imem_req_valid, imem_req_addr);
        end
        wait_inst(ok);
        checks++;
        if (!ok || inst_pc !== 32'h8000_000C || inst_err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear got ok=%b pc=%h e=%b want 1 8000000c 0", ok, inst_pc, inst_err);
        end
        err_addr = 32'h1;
    endtask

    task automatic test_ebreak();
        bit ok;
        ovr_addr       = 32'h8000_0020;
        ovr_data       = 32'h0010_0073;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0020;
        tick();
        redirect_valid = 1'b0;
        wait_inst(ok);
        checks++;
        if (!ok || inst !== 32'h0010_0073 || inst_pc !== 32'h8000_0020) begin
            errors++;
            $display("FAIL eb_arrive got ok=%b i=%h pc=%h want 1 00100073 80000020", ok, inst, inst_pc);
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
`ifdef YSYX_23060184_IFU_EBREAK_HALT_EN
        begin
            int r0;
            checks++;
            if (halted !== 1'b1 || imem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL eb_halt got h=%b req=%b want 1 0", halted, imem_req_valid);
            end
            r0 = n_req;
            for (int i = 0; i < 10; i++) begin
                tick();
                checks++;
                if (imem_req_valid !== 1'b0 || halted !== 1'b1) begin
                    errors++;
                    $display("FAIL eb_quiet[%0d] got req=%b h=%b want 0 1", i, imem_req_valid, halted);
                end
            end
            checks++;
            if (n_req !== r0) begin
                errors++;
                $display("FAIL eb_noreq got %0d want %0d", n_req, r0);
            end
            redirect_valid = 1'b1;
            redirect_pc    = 32'h8000_0000;
            tick();
            redirect_valid = 1'b0;
            checks++;
            if (halted !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin
                errors++;
                $display("FAIL eb_resume got h=%b v=%b a=%h want 0 1 80000000", halted, imem_req_valid, imem_req_addr);
            end
        end
`else
        checks++;
        if (halted !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0024) begin
            errors++;
            $display("FAIL eb_nohalt got h=%b v=%b a=%h want 0 1 80000024", halted, imem_req_valid, imem_req_addr);
        end
`endif
        ovr_addr = 32'h1;
    endtask

    // Random traffic against a model of the architectural PC stream.
    task automatic test_random();
        logic [31:0] exp_pc, p_inst, p_ipc, p_raddr;
        bit          p_iv, p_ir, p_rv, p_rr, p_rd, p_ierr;
        int          delivered;
        reset_dut();
        fixed_en  = 1'b0;
        err_pat   = 1'b1;
        exp_pc    = 32'h8000_0000;
        delivered = 0;
        {p_iv, p_ir, p_rv, p_rr, p_rd, p_ierr} = '0;
        p_inst = '0; p_ipc = '0; p_raddr = '0;
        for (int c = 0; c < 4000; c++) begin
            if (p_iv && !p_ir && !p_rd) begin
                checks++;
                if (inst_valid !== 1'b1 || inst !== p_inst || inst_pc !== p_ipc || inst_err !== p_ierr) begin
                    errors++;
                    $display("FAIL rnd_inst_hold c=%0d got v=%b pc=%h want 1 %h", c, inst_valid, inst_pc, p_ipc);
                end
            end
            if (p_rv && !p_rr && !p_rd) begin
                checks++;
                if (imem_req_valid !== 1'b1 || imem_req_addr !== p_raddr) begin
                    errors++;
                    $display("FAIL rnd_req_hold c=%0d got v=%b a=%h want 1 %h", c, imem_req_valid, imem_req_addr, p_raddr);
                end
            end
            inst_ready     = ($urandom_range(0, 2) != 0);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            lat_cur        = $urandom_range(1, 3);
            redirect_valid = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            else                           redirect_pc = 32'h8000_0000 + $urandom_range(0, 4095);
            if (imem_req_valid === 1'b1 && imem_req_ready && !redirect_valid) begin
                checks++;
                if (imem_req_addr !== exp_pc) begin
                    errors++;
                    $display("FAIL rnd_req_addr c=%0d got %h want %h", c, imem_req_addr, exp_pc);
                end
            end
            if (inst_valid === 1'b1 && inst_ready) begin
                checks++;
                if (inst_pc !== exp_pc || inst !== mem_data(exp_pc) || inst_err !== mem_err(exp_pc)) begin
                    errors++;
                    $display("FAIL rnd_inst c=%0d got pc=%h i=%h e=%b want %h %h %b",
                             c, inst_pc, inst, inst_err, exp_pc, mem_data(exp_pc), mem_err(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            if (redirect_valid) exp_pc = redirect_pc & ~32'h3;
            p_iv = (inst_valid === 1'b1); p_ir = inst_ready; p_inst = inst; p_ipc = inst_pc; p_ierr = inst_err;
            p_rv = (imem_req_valid === 1'b1); p_rr = imem_req_ready; p_raddr = imem_req_addr;
            p_rd = redirect_valid;
            tick();
        end
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        err_pat        = 1'b0;
        checks++;
        if (delivered < 150 || overlap) begin
            errors++;
            $display("FAIL rnd_progress got n=%0d ovl=%b want >=150 0", delivered, overlap);
        end
    endtask

    initial begin
        clk            = 1'b0;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_err   = 1'b0;
        inst_ready     = 1'b0;
        pend           = 1'b0;
        pend_cnt       = 0;
        pend_addr      = 32'h0;
        lat_cur        = 1;
        overlap        = 1'b0;
        fixed_en       = 1'b1;
        err_pat        = 1'b0;
        ovr_addr       = 32'h1;
        ovr_data       = 32'h0;
        err_addr       = 32'h1;
        n_req          = 0;
        n_inst         = 0;
        last_inst_pc   = 32'h0;

        test_reset();
        test_zero_wait();
        test_stall();
        test_redirect_wait();
        test_redirect_handshake();
        test_err();
        test_ebreak();
        test_random();
        test_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
